mult_div_unit: RTL and testbench

- Sequential signed multiply/divide engine. It sits directly downstream of the ALU control decoder.
- It consumes the decoder's multOp/divOp strobes and the A/B operand registers, and produces HI/LO results.
- HI/LO results feed the HI/LO registers. The StoreMD path selects which completed result is written there.
- The control FSM waits on busy/done. div0 feeds the exception logic.

---
 rtl/mult_div_unit.sv | 159 +++++++++++++++
 tb/tb_mult_div_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide engine: radix-2 Booth multiply and restoring
// divide on magnitudes, one iteration per clock, results held in hi/lo.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multOp,
  input  logic             divOp,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MULT   = 2'd1;
  localparam logic [1:0] DIV    = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  logic [1:0]       state;
  logic             armed;
  logic [CW-1:0]    count;
  logic             is_div;
  logic             is_div0;
  logic             neg_q;
  logic             neg_r;
  logic [2*WIDTH:0] acc;
  logic [WIDTH-1:0] mcand;  // multiplicand, or divisor magnitude when dividing
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;

  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   booth_upper;
  logic [WIDTH:0]   booth_m;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  assign accept    = (state == IDLE) && armed && (multOp || divOp);
  assign last_iter = (count == CW'(WIDTH - 1));
  assign a_mag     = a[WIDTH-1] ? -a : a;
  assign b_mag     = b[WIDTH-1] ? -b : b;

  // Booth add/sub is done one bit wider so the most negative multiplicand cannot overflow.
  assign booth_upper = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
  assign booth_m     = {mcand[WIDTH-1], mcand};

  always_comb begin
    booth_sum = booth_upper;
    case (acc[1:0])
      2'b01:   booth_sum = booth_upper + booth_m;
      2'b10:   booth_sum = booth_upper - booth_m;
      default: booth_sum = booth_upper;
    endcase
  end

  assign shifted = {rem, quot[WIDTH-1]};
  assign diff    = shifted - {1'b0, mcand};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      armed   <= 1'b1;
      count   <= '0;
      is_div  <= 1'b0;
      is_div0 <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      rem     <= '0;
      quot    <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      div0    <= 1'b0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      // A level held across cycles only starts once; ops must drop to re-arm.
      if (accept)
        armed <= 1'b0;
      else if (!multOp && !divOp)
        armed <= 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            busy    <= 1'b1;
            count   <= '0;
            is_div  <= divOp;
            neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r   <= a[WIDTH-1];
            is_div0 <= 1'b0;
            if (divOp) begin
              mcand <= b_mag;
              rem   <= '0;
              quot  <= a_mag;
              if (b == '0) begin
                is_div0 <= 1'b1;
                state   <= FINISH;
              end else begin
                state <= DIV;
              end
            end else begin
              mcand <= a;
              acc   <= {{WIDTH{1'b0}}, b, 1'b0};
              state <= MULT;
            end
          end
        end
        MULT: begin
          acc   <= {booth_sum, acc[WIDTH:1]};
          count <= count + 1'b1;
          if (last_iter)
            state <= FINISH;
        end
        DIV: begin
          if (!diff[WIDTH]) begin
            rem  <= diff[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b1};
          end else begin
            rem  <= shifted[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (last_iter)
            state <= FINISH;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
          // Divide by zero leaves the previous hi/lo untouched.
          if (is_div0) begin
            div0 <= 1'b1;
          end else if (is_div) begin
            hi <= neg_r ? -rem : rem;
            lo <= neg_q ? -quot : quot;
          end else begin
            hi <= acc[2*WIDTH:WIDTH+1];
            lo <= acc[WIDTH:1];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed test-plan cases plus random operations
// checked against a plain-arithmetic signed reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        multOp = 1'b0;
  logic        divOp = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div0;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .multOp(multOp), .divOp(divOp),
    .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done), .div0(div0)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-number signed arithmetic on 64-bit values.
  task automatic model_op(input logic do_div, input logic [31:0] av, input logic [31:0] bv,
                          output int exp_lat, output logic exp_div0);
    longint sa, sb, q, r, p;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    exp_div0 = 1'b0;
    exp_lat  = 33;
    if (do_div) begin
      if (bv == 32'd0) begin
        exp_div0 = 1'b1;
        exp_lat  = 1;
      end else begin
        q = sa / sb;
        r = sa % sb;
        model_lo = q[31:0];
        model_hi = r[31:0];
      end
    end else begin
      p = sa * sb;
      model_hi = p[63:32];
      model_lo = p[31:0];
    end
  endtask

  task automatic run_op(input logic do_div, input logic [31:0] av, input logic [31:0] bv,
                        input string tag);
    int exp_lat, edges, busy_n;
    logic exp_div0;
    model_op(do_div, av, bv, exp_lat, exp_div0);
    multOp = !do_div;
    divOp  = do_div;
    a = av;
    b = bv;
    @(posedge clk); #1;
    multOp = 1'b0;
    divOp  = 1'b0;
    a = $urandom;
    b = $urandom;
    check({tag, ".busy_at_accept"}, 64'(busy), 64'd1);
    edges  = 0;
    busy_n = 1;
    while (!done && edges < 60) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_n++;
    end
    check({tag, ".latency"}, 64'(edges), 64'(exp_lat));
    check({tag, ".busy_cycles"}, 64'(busy_n), 64'(exp_lat));
    check({tag, ".hi"}, 64'(hi), 64'(model_hi));
    check({tag, ".lo"}, 64'(lo), 64'(model_lo));
    check({tag, ".div0"}, 64'(div0), 64'(exp_div0));
    @(posedge clk); #1;
    check({tag, ".done_clear"}, 64'({done, div0}), 64'd0);
    $display("op %s div=%0d a=%h b=%h -> hi=%h lo=%h div0_exp=%0d", tag, do_div, av, bv, hi, lo, exp_div0);
  endtask

  initial begin
    int pulses, edges;
    logic [31:0] specials [4];
    logic [31:0] av, bv;
    logic do_div;
    specials[0] = 32'h8000_0000;
    specials[1] = 32'hFFFF_FFFF;
    specials[2] = 32'h0000_0000;
    specials[3] = 32'h0000_0001;

    #12;
    check("reset.outputs", {hi, lo}, 64'd0);
    check("reset.flags", 64'({busy, done, div0}), 64'd0);
    #10 reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset.idle", 64'({busy, done}), 64'd0);

    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, "mul_7x-3");
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, "mul_min_min");
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_-1x-1");
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, "div_-7/2");
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7/-2");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    run_op(1'b0, 32'd5, 32'd6, "mul_5x6");
    run_op(1'b1, 32'd123, 32'd0, "div_by_zero");

    // Held strobe: exactly one operation for a 40-cycle level.
    multOp = 1'b1;
    a = 32'd1000;
    b = 32'hFFFF_FC18;
    model_hi = 32'hFFFF_FFFF;
    model_lo = 32'hFFF0_BDC0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    multOp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("held.done_count", 64'(pulses), 64'd1);
    check("held.hi", 64'(hi), 64'(model_hi));
    check("held.lo", 64'(lo), 64'(model_lo));
    $display("op held_mult hi=%h lo=%h pulses=%0d", hi, lo, pulses);

    // divOp raised mid-multiply must be ignored.
    multOp = 1'b1;
    a = 32'h0001_2345;
    b = 32'hFFFF_0003;
    begin
      int lat; logic d0;
      model_op(1'b0, 32'h0001_2345, 32'hFFFF_0003, lat, d0);
    end
    @(posedge clk); #1;
    multOp = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    divOp = 1'b1;
    b = 32'd0;
    @(posedge clk); #1;
    divOp = 1'b0;
    edges = 6;
    pulses = 0;
    while (!done && edges < 80) begin
      @(posedge clk); #1;
      edges++;
    end
    check("busy_ignore.latency", 64'(edges), 64'd33);
    check("busy_ignore.div0", 64'(div0), 64'd0);
    check("busy_ignore.hi", 64'(hi), 64'(model_hi));
    check("busy_ignore.lo", 64'(lo), 64'(model_lo));
    repeat (3) begin @(posedge clk); #1; if (busy || done) pulses++; end
    check("busy_ignore.no_queue", 64'(pulses), 64'd0);
    $display("op busy_ignore hi=%h lo=%h", hi, lo);
    run_op(1'b0, 32'd3, 32'd9, "mul_rearm");

    // Asynchronous reset in the middle of a divide.
    divOp = 1'b1;
    a = 32'd1_000_000;
    b = 32'd7;
    @(posedge clk); #1;
    divOp = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    check("async_reset.hilo", {hi, lo}, 64'd0);
    check("async_reset.busy", 64'({busy, done}), 64'd0);
    model_hi = '0;
    model_lo = '0;
    #2 reset = 1'b0;
    $display("op async_reset hi=%h lo=%h busy=%0d", hi, lo, busy);
    run_op(1'b0, 32'hFFFF_FF00, 32'd77, "mul_after_reset");

    for (int i = 0; i < 20; i++) begin
      do_div = 1'($urandom_range(0, 1));
      av = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      case ($urandom_range(0, 5))
        0:       bv = specials[$urandom_range(0, 3)];
        1:       bv = 32'($urandom_range(1, 20));
        default: bv = $urandom;
      endcase
      run_op(do_div, av, bv, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
